// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back controller.
// Grant encoding and the captured write-back request live here.
package rf_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LD  = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter for the single register-file write port.
// req/gnt bit 0 is the ALU stream, bit 1 is the load stream.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    grant_e last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_ALU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_grant <= GNT_LD;
        end else if (gnt[0]) begin
            last_grant <= GNT_ALU;
        end else if (gnt[1]) begin
            last_grant <= GNT_LD;
        end
    end

endmodule

// File: rtl/regfile_wb_controller.sv
// Write-back controller: arbitrates ALU/load results onto the register-file
// write port, registers the write, and tracks pending destinations for decode.
module regfile_wb_controller
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              flush,
    output logic              reg_write,
    output logic [ADDR_W-1:0] regd,
    output logic [DATA_W-1:0] write_data
);

    logic [1:0]          gnt;
    logic                accept;
    wb_req_t             sel_req;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .nrst (nrst),
        .req  ({ld_valid, alu_valid}),
        .gnt  (gnt)
    );

    assign alu_ready = gnt[0];
    assign ld_ready  = gnt[1];
    assign accept    = |gnt;

    always_comb begin
        sel_req = '0;
        if (gnt[1]) begin
            sel_req.rd   = ld_rd;
            sel_req.data = ld_data;
        end else if (gnt[0]) begin
            sel_req.rd   = alu_rd;
            sel_req.data = alu_data;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            reg_write  <= 1'b0;
            regd       <= '0;
            write_data <= '0;
        end else begin
            reg_write <= accept && (sel_req.rd != '0);
            if (accept && (sel_req.rd != '0)) begin
                regd       <= sel_req.rd;
                write_data <= sel_req.data;
            end
        end
    end

    assign issue_ready = (issue_rd == '0) || !pending[issue_rd] ||
                         (reg_write && (regd == issue_rd));

    assign rs1_busy = (rs1 != '0) && pending[rs1] && !(reg_write && (regd == rs1));
    assign rs2_busy = (rs2 != '0) && pending[rs2] && !(reg_write && (regd == rs2));

    // Order matters: clear, then set (new producer wins), then flush overrides all.
    always_comb begin
        pending_next = pending;
        if (reg_write) begin
            pending_next[regd] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            pending_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            pending_next = '0;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Scoreboard bench for regfile_wb_controller: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever reg_write is asserted.
module tb_regfile_wb_controller;
    import rf_pkg::*;

    logic              clk = 1'b0;
    logic              nrst;
    logic              alu_valid, ld_valid, issue_valid, flush;
    logic              alu_ready, ld_ready, issue_ready;
    logic [ADDR_W-1:0] alu_rd, ld_rd, issue_rd, rs1, rs2;
    logic [DATA_W-1:0] alu_data, ld_data;
    logic              rs1_busy, rs2_busy, reg_write;
    logic [ADDR_W-1:0] regd;
    logic [DATA_W-1:0] write_data;

    int total = 0;
    int bad   = 0;
    wb_req_t exp_q[$];

    regfile_wb_controller dut (
        .clk         (clk),
        .nrst        (nrst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .flush       (flush),
        .reg_write   (reg_write),
        .regd        (regd),
        .write_data  (write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        wb_req_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every reg_write cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (nrst && reg_write) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got regd=%0d data=0x%08h expected no write", regd, write_data);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                check("wb_regd", 32'(regd), 32'(e.rd));
                check("wb_data", write_data, e.data);
            end
        end
    end

    initial begin
        nrst = 1'b0;
        alu_valid = 0; ld_valid = 0; issue_valid = 0; flush = 0;
        alu_rd = 0; ld_rd = 0; issue_rd = 5; rs1 = 5; rs2 = 6;
        alu_data = 0; ld_data = 0;
        #12;
        check("rst_reg_write", 32'(reg_write), 0);
        check("rst_regd", 32'(regd), 0);
        check("rst_write_data", write_data, 0);
        check("rst_alu_ready", 32'(alu_ready), 0);
        check("rst_ld_ready", 32'(ld_ready), 0);
        check("rst_issue_ready", 32'(issue_ready), 1);
        check("rst_rs1_busy", 32'(rs1_busy), 0);
        step();
        nrst = 1'b1;
        step();

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("single_alu_ready", 32'(alu_ready), 1);
        push(5, 32'hDEADBEEF);
        step();
        alu_valid = 0;
        check("single_reg_write_c1", 32'(reg_write), 1);
        step();
        check("single_reg_write_c2", 32'(reg_write), 0);

        // Contention from reset: ALU, LD, ALU, LD
        nrst = 0; #1; nrst = 1;
        step();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hAAAA0003;
        ld_valid  = 1; ld_rd  = 4; ld_data  = 32'hBBBB0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_alu_ready", 32'(alu_ready), (i % 2 == 0) ? 1 : 0);
            check("rr_ld_ready", 32'(ld_ready), (i % 2 == 0) ? 0 : 1);
            if (i % 2 == 0) push(3, 32'hAAAA0003);
            else            push(4, 32'hBBBB0004);
            step();
            if (i > 0 || 1) check("rr_reg_write", 32'(reg_write), 1);
        end
        alu_valid = 0; ld_valid = 0;
        step();

        // Reservation of x7 and RAW/WAW hazards until write-back
        issue_valid = 1; issue_rd = 7;
        #1 check("iss7_ready", 32'(issue_ready), 1);
        step();
        issue_valid = 0; rs1 = 7; rs2 = 0;
        #1;
        check("rs1_busy_7", 32'(rs1_busy), 1);
        check("rs2_zero_busy", 32'(rs2_busy), 0);
        check("iss7_waw_stall", 32'(issue_ready), 0);
        step();
        check("rs1_busy_7_hold", 32'(rs1_busy), 1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h00000077;
        push(7, 32'h00000077);
        step();
        alu_valid = 0;
        check("wb7_reg_write", 32'(reg_write), 1);
        check("rs1_busy_7_bypass", 32'(rs1_busy), 0);
        check("iss7_ready_bypass", 32'(issue_ready), 1);
        step();
        check("rs1_busy_7_cleared", 32'(rs1_busy), 0);

        // Load to x0: consumed, never written
        ld_valid = 1; ld_rd = 0; ld_data = 32'h00001234;
        #1 check("ld_x0_ready", 32'(ld_ready), 1);
        step();
        ld_valid = 0;
        check("ld_x0_no_write", 32'(reg_write), 0);
        step();
        check("ld_x0_no_write2", 32'(reg_write), 0);
        check("ld_x0_pending", 32'(rs1_busy), 0);

        // Set and clear x9 on the same edge: set wins
        issue_valid = 1; issue_rd = 9;
        step();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99990009;
        push(9, 32'h99990009);
        step();
        alu_valid = 0;
        issue_valid = 1; issue_rd = 9;
        #1 check("iss9_ready_same_edge", 32'(issue_ready), 1);
        step();
        issue_valid = 0; rs1 = 9;
        #1 check("rs1_busy_9_after", 32'(rs1_busy), 1);

        // Flush overrides a same-cycle reservation
        flush = 1; issue_valid = 1; issue_rd = 10;
        step();
        flush = 0; issue_valid = 0; rs1 = 9; rs2 = 10;
        #1;
        check("flush_rs1_9", 32'(rs1_busy), 0);
        check("flush_rs2_10", 32'(rs2_busy), 0);
        step();

        // Reset mid-transfer drops the captured write
        issue_valid = 1; issue_rd = 12;
        step();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 12; alu_data = 32'hCCCC000C;
        step();
        alu_valid = 0;
        check("pre_rst_reg_write", 32'(reg_write), 1);
        nrst = 0;
        #1;
        check("mid_rst_reg_write", 32'(reg_write), 0);
        check("mid_rst_regd", 32'(regd), 0);
        check("mid_rst_write_data", write_data, 0);
        step();
        nrst = 1; rs1 = 12;
        #1 check("mid_rst_pending12", 32'(rs1_busy), 0);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33330003;
        ld_valid  = 1; ld_rd  = 4; ld_data  = 32'h44440004;
        #1;
        check("post_rst_tie_alu", 32'(alu_ready), 1);
        check("post_rst_tie_ld", 32'(ld_ready), 0);
        push(3, 32'h33330003);
        step();
        alu_valid = 0; ld_valid = 0;
        step();
        step();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_controller.md
# regfile_wb_controller

Write-back controller for the 32x32 integer register file: arbitrates the single register-file write port between the ALU and load-unit result streams and keeps a pending-write scoreboard. It sits between execute/memory stages and the register file, driving the file's write-enable, destination and data inputs. Decode queries it for source-operand hazards and destination conflicts.

## Interface
- NUM_REGS, 32, architectural register count (x0 hard-wired zero)
- ADDR_W, 5, register index width
- DATA_W, 32, write data width
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous and active-low
- alu_valid / alu_ready  in / out  1  ALU write-back handshake
- alu_rd  in  ADDR_W  ALU destination; alu_data  in  DATA_W  ALU result
- ld_valid / ld_ready  in / out  1  load write-back handshake
- ld_rd  in  ADDR_W  load destination; ld_data  in  DATA_W  load result
- issue_valid  in  1  decode issuing an instruction that writes issue_rd
- issue_rd  in  ADDR_W  destination being reserved
- issue_ready  out  1  reservation possible this cycle
- rs1, rs2  in  ADDR_W  decode source indices
- rs1_busy, rs2_busy  out  1  source has a pending write
- flush  in  1  pipeline flush, clears reservations
- reg_write  out  1  register-file write enable
- regd  out  ADDR_W  register-file destination
- write_data  out  DATA_W  register-file write data

## Operation
- Handshake: transfer on valid && ready same cycle; at most one transfer per cycle total; requesters hold rd/data stable while valid && !ready.
- Arbitration: 2-way round-robin. One valid → that one granted. Both valid → the one not granted last time; last_grant updates only on transfer. After reset ALU wins the first tie.
- ready is combinational from valid inputs and last_grant; the loser sees ready=0.
- Accepted request registered into output stage: next cycle reg_write=1 for exactly one cycle with captured rd/data. Accepted request with rd=0: consumed (ready=1), reg_write stays 0, no scoreboard effect.
- Scoreboard: NUM_REGS-bit pending vector, bit 0 constant 0.
  - Set: issue_valid && issue_ready && issue_rd!=0 sets pending[issue_rd] on next edge.
  - Clear: reg_write cycle clears pending[regd] on that edge.
  - Same register set and cleared same edge → set wins (new producer).
- issue_ready = (issue_rd==0) || !pending[issue_rd] || (reg_write && regd==issue_rd). WAW reservations otherwise stalled.
- rsN_busy = pending[rsN] && !(reg_write && regd==rsN); rsN=0 never busy. Combinational.
- flush: clears all pending bits on next edge, overrides same-cycle set; an in-flight output write still commits; does not block handshakes.
- Write-back to a register with no pending bit: write still performed; clear is harmless.

## Timing
- Reset (nrst=0, asynchronous): reg_write=0, regd=0, write_data=0, pending=0, last_grant=load (so ALU wins first tie). alu_ready/ld_ready follow valids combinationally; all valids low → both 0. issue_ready=1, rsN_busy=0.
- Reset mid-transfer: captured write dropped, no reg_write after release; requesters re-present.
- Latency: accept edge N → reg_write high in cycle N+1, register file updated at edge N+2... i.e. file written on the edge ending cycle N+1; pending clear on that same edge.
- Throughput: one write per cycle sustained; alternating grants under continuous contention.
- No combinational path from ready to valid inside the block.

## Structure
- Package rf_pkg: ADDR_W, DATA_W, NUM_REGS constants; wb_req_t struct {rd, data}; grant enum {GNT_ALU, GNT_LD}.
- Sub-module rr_arbiter2: two requests, last_grant register, grant vector out; instantiated once.
- Scoreboard and output register stage inline in regfile_wb_controller.

## Test plan
- Reset then single ALU write rd=5, data=0xDEADBEEF → alu_ready=1 cycle 0, reg_write=1 regd=5 write_data=0xDEADBEEF cycle 1, reg_write=0 cycle 2.
- ALU and load valid continuously (rd=3 / rd=4) for 4 cycles → grants ALU, LD, ALU, LD; reg_write every cycle; loser's ready=0 each cycle.
- Issue rd=7, then rs1=7 → rs1_busy=1 until the write-back of rd=7 reaches reg_write (busy=0 that cycle); second issue rd=7 sees issue_ready=0 until then.
- Load write-back rd=0 data=0x1234 → ld_ready=1, reg_write never asserted, pending unchanged.
- Issue rd=9 same cycle as reg_write regd=9 → pending[9]=1 afterward; flush with issue rd=10 same cycle → pending all zero.
- Assert nrst low in cycle after accept → reg_write, regd, write_data 0 immediately; pending cleared; next tie after release granted to ALU.
